// File: rtl/spi_sample_framer.sv
// spi_sample_framer
//   Collects words from the SPI slave into fixed-length frames held in a
//   two-bank (ping-pong) buffer. Completed frames are streamed in arrival
//   order to the DFT core over valid/ready, tagged with sample index and a
//   last flag. A registered status word is returned to the SPI slave.
//
// Ports
//   i_sys_clk    system clock, rising edge
//   i_sys_rst_n  asynchronous active-low reset
//   i_rx_data    sample word from the SPI slave
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   o_smp_data   frame sample to the DFT
//   o_smp_idx    position of o_smp_data inside its frame
//   o_smp_valid  o_smp_data / o_smp_idx / o_smp_last are valid
//   o_smp_last   marks index FRAME_LEN-1
//   i_smp_ready  DFT accepts the sample on valid && ready
//   o_tx_word    status {ovf, full[1], full[0], frame_cnt[0], drop_cnt}
//   o_overflow   sticky: at least one sample was dropped
//   i_clr_ovf    synchronous clear of o_overflow and the drop counter
//
// Build option
//   SPI_FRAMER_OFFSET_BIN_EN : when defined, the sample MSB is inverted on
//   write so offset-binary ADC codes leave as two's complement.
//
// Read FSM
//   state    | meaning
//   S_IDLE   | no frame being streamed; waiting for full[rb]
//   S_STREAM | streaming bank rb through the output register

module spi_sample_framer #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_smp_data,
    output logic [IDX_W-1:0]  o_smp_idx,
    output logic              o_smp_valid,
    output logic              o_smp_last,
    input  logic              i_smp_ready,
    output logic [DATA_W-1:0] o_tx_word,
    output logic              o_overflow,
    input  logic              i_clr_ovf
);

    localparam int               DROP_W   = DATA_W - 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];

    logic              wb;
    logic              rb;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [DROP_W-1:0] drop_cnt;
    logic [3:0]        frame_cnt;
    logic [DATA_W-1:0] wr_data;

    logic              ld_en;
    logic              ld_bank;
    logic [IDX_W-1:0]  ld_idx;
    logic              rd_release;
    logic              bank_busy;
    logic              wr_en;
    logic              drop;

`ifdef SPI_FRAMER_OFFSET_BIN_EN
    assign wr_data = i_rx_data ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
    assign wr_data = i_rx_data;
`endif

    // FSM state register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (full[rb]) state_nxt = S_STREAM;
            S_STREAM: if (rd_release && !full[~rb]) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: output-register load and bank release.
    // After the last sample of a frame is taken, the next frame's first
    // sample is loaded in the same cycle if the other bank is already full.
    always_comb begin
        ld_en      = 1'b0;
        ld_bank    = rb;
        ld_idx     = '0;
        rd_release = 1'b0;
        case (state)
            S_STREAM: begin
                if (!o_smp_valid || i_smp_ready) begin
                    if (o_smp_valid && o_smp_last) begin
                        rd_release = 1'b1;
                        ld_bank    = ~rb;
                        ld_en      = full[~rb];
                    end else begin
                        ld_en  = 1'b1;
                        ld_idx = o_smp_valid ? (o_smp_idx + IDX_W'(1)) : '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // A bank being released this cycle already counts as empty for the writer.
    always_comb begin
        bank_busy = full[wb] && !(rd_release && (rb == wb));
        wr_en     = i_rx_valid && !bank_busy;
        drop      = i_rx_valid && bank_busy;
        full_nxt  = full;
        if (rd_release) full_nxt[rb] = 1'b0;
        if (wr_en && (wr_idx == LAST_IDX)) full_nxt[wb] = 1'b1;
    end

    always_ff @(posedge i_sys_clk) begin
        if (wr_en) mem[{wb, wr_idx}] <= wr_data;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            wb          <= 1'b0;
            rb          <= 1'b0;
            wr_idx      <= '0;
            full        <= '0;
            drop_cnt    <= '0;
            frame_cnt   <= '0;
            o_overflow  <= 1'b0;
            o_tx_word   <= '0;
            o_smp_data  <= '0;
            o_smp_idx   <= '0;
            o_smp_valid <= 1'b0;
            o_smp_last  <= 1'b0;
        end else begin
            full <= full_nxt;

            if (wr_en) begin
                wr_idx <= wr_idx + IDX_W'(1);
                if (wr_idx == LAST_IDX) wb <= ~wb;
            end

            // A drop in the same cycle as a clear leaves exactly one drop recorded.
            if (drop) begin
                o_overflow <= 1'b1;
                if (i_clr_ovf) begin
                    drop_cnt <= DROP_W'(1);
                end else if (drop_cnt != {DROP_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
                drop_cnt   <= '0;
            end

            if (rd_release) begin
                rb        <= ~rb;
                frame_cnt <= frame_cnt + 4'd1;
            end

            if (ld_en) begin
                o_smp_data  <= mem[{ld_bank, ld_idx}];
                o_smp_idx   <= ld_idx;
                o_smp_last  <= (ld_idx == LAST_IDX);
                o_smp_valid <= 1'b1;
            end else if (rd_release) begin
                o_smp_valid <= 1'b0;
                o_smp_last  <= 1'b0;
            end

            o_tx_word <= {o_overflow, full[1], full[0], frame_cnt[0], drop_cnt};
        end
    end

endmodule

// File: tb/tb_spi_sample_framer.sv
`timescale 1ns/1ps
module tb_spi_sample_framer;

    localparam int DATA_W = 12;
    localparam int FLEN   = 4;
    localparam int IDX_W  = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] rx_data  = '0;
    logic              rx_valid = 1'b0;
    logic              ready    = 1'b0;
    logic              clr      = 1'b0;
    logic [DATA_W-1:0] smp_data;
    logic [IDX_W-1:0]  smp_idx;
    logic              smp_valid;
    logic              smp_last;
    logic [DATA_W-1:0] tx_word;
    logic              overflow;

    always #5 clk = ~clk;

    spi_sample_framer #(.DATA_W(DATA_W), .FRAME_LEN(FLEN), .IDX_W(IDX_W)) dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_smp_data  (smp_data),
        .o_smp_idx   (smp_idx),
        .o_smp_valid (smp_valid),
        .o_smp_last  (smp_last),
        .i_smp_ready (ready),
        .o_tx_word   (tx_word),
        .o_overflow  (overflow),
        .i_clr_ovf   (clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d);
`ifdef SPI_FRAMER_OFFSET_BIN_EN
        return d ^ 12'h800;
`else
        return d;
`endif
    endfunction

    // Model: frames are a flat stream of samples; the buffer holds at most
    // two completed, unreleased frames. Frame ordinal k lives in bank k%2.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur_q[$];
    int                out_pos = 0;
    int                n_done  = 0;
    int                n_rel   = 0;
    logic              m_ovf   = 1'b0;
    int                m_drops = 0;
    logic [DATA_W-1:0] tx_pending = '0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [IDX_W-1:0]  prev_idx;
    logic              prev_last;
    int                cyc = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  idx;
        logic              last;
        int                cyc;
    } hs_t;
    hs_t log_q[$];

    function automatic logic model_full(input int b);
        for (int k = n_rel; k < n_done; k++) if ((k % 2) == b) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        logic hs, rel, dropped;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            cur_q.delete();
            out_pos    = 0;
            n_done     = 0;
            n_rel      = 0;
            m_ovf      = 1'b0;
            m_drops    = 0;
            tx_pending = '0;
            prev_stall = 1'b0;
        end else begin
            check("tx_word", tx_word, tx_pending);
            check("overflow", overflow, m_ovf);
            if (prev_stall) begin
                check("stall_valid", smp_valid, 1'b1);
                check("stall_data", smp_data, prev_data);
                check("stall_idx", smp_idx, prev_idx);
                check("stall_last", smp_last, prev_last);
            end
            if (smp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_valid: got valid with data 0x%0h, expected no pending sample", smp_data);
                end else begin
                    check("smp_data", smp_data, exp_q[0]);
                    check("smp_idx", smp_idx, out_pos % FLEN);
                    check("smp_last", smp_last, (out_pos % FLEN) == FLEN - 1);
                end
            end
            hs = smp_valid && ready;
            if (hs) log_q.push_back('{smp_data, smp_idx, smp_last, cyc});
            prev_stall = smp_valid && !ready;
            prev_data  = smp_data;
            prev_idx   = smp_idx;
            prev_last  = smp_last;

            tx_pending = {m_ovf, model_full(1), model_full(0), n_rel[0], m_drops[7:0]};

            if (hs && exp_q.size() != 0) begin
                rel = ((out_pos % FLEN) == FLEN - 1);
                void'(exp_q.pop_front());
                out_pos++;
                if (rel) n_rel++;
            end
            dropped = 1'b0;
            if (rx_valid) begin
                if (n_done - n_rel == 2) begin
                    dropped = 1'b1;
                    m_ovf   = 1'b1;
                    if (clr) m_drops = 1;
                    else if (m_drops < 255) m_drops++;
                end else begin
                    cur_q.push_back(xform(rx_data));
                    if (cur_q.size() == FLEN) begin
                        foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
                        cur_q.delete();
                        n_done++;
                    end
                end
            end
            if (clr && !dropped) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", smp_valid, 1'b0);
        check("rst_data", smp_data, 0);
        check("rst_idx", smp_idx, 0);
        check("rst_last", smp_last, 1'b0);
        check("rst_tx", tx_word, 0);
        check("rst_ovf", overflow, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [DATA_W-1:0] t1_vals [4];
        logic [DATA_W-1:0] t6_in   [4];
        logic [DATA_W-1:0] t6_exp  [4];
        int w;
        t1_vals = '{12'h001, 12'h003, 12'h008, 12'h002};
        t6_in   = '{12'h800, 12'h000, 12'hFFF, 12'h7FF};
`ifdef SPI_FRAMER_OFFSET_BIN_EN
        t6_exp  = '{12'h000, 12'h800, 12'h7FF, 12'hFFF};
`else
        t6_exp  = '{12'h800, 12'h000, 12'hFFF, 12'h7FF};
`endif

        // single frame, always ready
        apply_reset();
        ready = 1'b1;
        log_q.delete();
        for (int i = 0; i < 4; i++) send(t1_vals[i]);
        check("t1_lat_edge0", smp_valid, 1'b0);
        idle(1);
        check("t1_lat_edge1", smp_valid, 1'b0);
        idle(1);
        check("t1_first_valid", smp_valid, 1'b1);
        check("t1_first_data", smp_data, xform(12'h001));
        idle(6);
        check("t1_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("t1_data", log_q[i].d, xform(t1_vals[i]));
            check("t1_idx", log_q[i].idx, i);
            check("t1_last", log_q[i].last, i == 3);
        end
        check("t1_tx_frame_cnt", tx_word, 12'h100);

        // both banks full, overflow, clear, saturation, back-to-back drain
        apply_reset();
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(12'(i));
        idle(2);
        check("t2_both_full", tx_word, 12'h600);
        check("t2_held_valid", smp_valid, 1'b1);
        for (int i = 0; i < 3; i++) send(12'h0F0 + 12'(i));
        idle(2);
        check("t3_ovf_set", overflow, 1'b1);
        check("t3_tx_3drops", tx_word, 12'hE03);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(2);
        check("t3_ovf_clr", overflow, 1'b0);
        check("t3_tx_clr", tx_word, 12'h600);
        clr = 1'b1;
        send(12'h055);
        clr = 1'b0;
        idle(2);
        check("t3_drop_beats_clr", tx_word, 12'hE01);
        repeat (260) send(12'h066);
        idle(2);
        check("t3_drop_saturate", tx_word, 12'hEFF);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(2);
        check("t3_tx_clr2", tx_word, 12'h600);
        log_q.delete();
        ready = 1'b1;
        idle(12);
        check("t2_count", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            check("t2_data", log_q[i].d, xform(12'(i + 1)));
            check("t2_idx", log_q[i].idx, i % 4);
        end
        for (int i = 1; i < 8 && i < log_q.size(); i++)
            check("t2_no_gap", log_q[i].cyc - log_q[i-1].cyc, 1);
        check("t2_tx_after", tx_word, 12'h000);

        // random ready stalls over 16 frames
        apply_reset();
        log_q.delete();
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    send(12'(i * 37 + 5));
                    idle(2);
                end
            end
            begin
                repeat (212) begin
                    ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        ready = 1'b1;
        w = 0;
        while ((exp_q.size() != 0 || smp_valid) && w < 200) begin
            idle(1);
            w++;
        end
        check("t4_drain_timeout", w < 200, 1'b1);
        idle(2);
        check("t4_count", log_q.size(), 64);
        check("t4_no_ovf", overflow, 1'b0);
        check("t4_tx", tx_word, 12'h000);

        // reset mid-stream with one bank full
        apply_reset();
        ready = 1'b0;
        send(12'h111); send(12'h222); send(12'h333); send(12'h444);
        send(12'h555); send(12'h666);
        idle(3);
        check("t5_pre_valid", smp_valid, 1'b1);
        check("t5_pre_tx_full0", tx_word, 12'h200);
        apply_reset();
        ready = 1'b1;
        log_q.delete();
        send(12'h00A); send(12'h00B); send(12'h00C); send(12'h00D);
        idle(6);
        check("t5_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("t5_data", log_q[i].d, xform(12'h00A + 12'(i)));
            check("t5_idx", log_q[i].idx, i);
        end

        // offset-binary conversion vectors
        log_q.delete();
        for (int i = 0; i < 4; i++) send(t6_in[i]);
        idle(6);
        check("t6_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check("t6_data", log_q[i].d, t6_exp[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sample_framer.md
Name: spi_sample_framer

Overview:
- Sits directly downstream of the SPI slave interface.
- Collects the 12-bit words the slave delivers (o_data qualified by the o_data_ready pulse) into fixed-length frames in a ping-pong buffer.
- Streams each completed frame to the DFT core over a valid/ready interface, with sample index and last-flag.
- Drives a status word back to the slave's i_data so the SPI master can read framer health on its next transfer.

Parameters:
- DATA_W, 12, sample width; equals the SPI slave word width.
- FRAME_LEN, 16, samples per frame; power of two, minimum 2.
- IDX_W, $clog2(FRAME_LEN), width of the index fields.

Ports:
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_sys_rst_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  DATA_W  sample from the SPI slave (its o_data).
- i_rx_valid  in  1  one-cycle strobe from the SPI slave (its o_data_ready).
- o_smp_data  out  DATA_W  frame sample to the DFT.
- o_smp_idx  out  IDX_W  position of o_smp_data within its frame.
- o_smp_valid  out  1  o_smp_data, o_smp_idx and o_smp_last are valid.
- o_smp_last  out  1  asserted with idx FRAME_LEN-1.
- i_smp_ready  in  1  DFT accepts the sample when valid&&ready.
- o_tx_word  out  DATA_W  status word to the SPI slave's i_data.
- o_overflow  out  1  sticky; a sample was dropped.
- i_clr_ovf  in  1  synchronous clear of o_overflow and drop count.

Behaviour:
- Reset (asynchronous, any time, including mid-frame or mid-stream): all outputs 0; both banks empty; write bank 0; wr_idx 0; read FSM in IDLE; drop count 0; frame count 0. Buffer RAM contents are not reset.
- Write side:
  - On i_rx_valid, write i_rx_data to bank[wb][wr_idx], then increment wr_idx.
  - When wr_idx==FRAME_LEN-1 and the word is written: set full[wb], wrap wr_idx to 0, toggle wb.
- Overflow:
  - If i_rx_valid arrives while full[wb]=1, the sample is dropped.
  - wr_idx is held, o_overflow is set, and drop_cnt increments, saturating at 2^(DATA_W-4)-1.
- Read FSM, IDLE:
  - If full[rb]: go to STREAM, rd_idx=0.
  - rb starts at 0 and toggles after each frame, so frames leave in arrival order.
- Read FSM, STREAM:
  - The output register loads bank[rb][rd_idx] whenever !o_smp_valid || i_smp_ready.
  - The first sample appears 1 cycle after entering STREAM.
  - Each handshake advances rd_idx; o_smp_last=(o_smp_idx==FRAME_LEN-1).
  - Handshake on last: clear full[rb], toggle rb, increment frame_cnt (wraps, 4 bits).
  - If the other bank is already full, the next frame's first sample is loaded in the same cycle (back-to-back, no bubble); otherwise go to IDLE and o_smp_valid drops.
  - While o_smp_valid=1 and i_smp_ready=0, data, idx and last are held stable.
- Simultaneous events:
  - Read releasing bank X in the same cycle the writer completes bank Y: both happen, no conflict.
  - Writer arriving at bank X in the cycle X is released: the released bank counts as empty and the sample is written (no drop).
  - i_clr_ovf coinciding with a drop: the drop wins; o_overflow=1 and drop_cnt=1.
- o_tx_word is registered and updated every cycle as {o_overflow, full[1], full[0], frame_cnt[0], drop_cnt[DATA_W-5:0]} for DATA_W=12, i.e. {ovf, f1, f0, lsb of frame_cnt, 8-bit drops}.
- Throughput: sustains one input per cycle with a continuously ready DFT; SPI word rate is far lower in practice.

Optional Feature:
- Macro SPI_FRAMER_OFFSET_BIN_EN.
- Defined: incoming samples are treated as offset-binary ADC codes; MSB is inverted on write, so o_smp_data is two's complement (0x800 in -> 0x000 out, 0x000 -> 0x800, 0xFFF -> 0x7FF).
- Undefined: samples pass through unmodified.
- o_tx_word is unaffected either way.

Test Plan:
- FRAME_LEN=4, feature off, i_smp_ready=1; send 1,3,8,2 -> o_smp_data 1,3,8,2 with idx 0..3; o_smp_last only on 2; first valid 2 cycles after the 4th strobe; frame_cnt=1.
- Send 8 samples 1..8 with i_smp_ready=0 -> both full bits set and o_tx_word[10:9]=11; raise ready -> 1..8 stream back-to-back with no valid gap between 4 and 5.
- With both banks full, send 3 more samples -> o_overflow=1, drop count 3, o_tx_word=0xE03; pulse i_clr_ovf -> o_overflow=0, low 8 bits 0.
- Stall ready randomly mid-frame -> data, idx and last stable while valid&&!ready; no sample lost or duplicated over 16 frames.
- Assert i_sys_rst_n low mid-stream with one bank full -> all outputs 0 immediately; afterwards a fresh 4-sample frame streams from idx 0.
- Feature on: send 0x800, 0x000, 0xFFF, 0x7FF -> outputs 0x000, 0x800, 0x7FF, 0xFFF.
